// File: rtl/prbs8_checker.sv
// Receive-side checker for the 8-bit PRBS byte stream: self-synchronises, then flags
// mismatching bytes and keeps saturating byte- and bit-error counters.
module prbs8_checker #(
    parameter logic [7:0] SEED         = 8'hBC,
    parameter int          LOCK_COUNT   = 4,
    parameter int          UNLOCK_COUNT = 4,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_count
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH_FIRST,
        SEARCH,
        LOCKED
    } state_t;

    state_t           state;
    logic [7:0]       ref_byte;
    logic [3:0]       run;
    logic [3:0]       miss_run;

    logic [7:0]       exp_byte;
    logic             mismatch;
    logic [3:0]       bit_errs;
    logic [CNT_W:0]   err_sum;
    logic [CNT_W:0]   bit_sum;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W-1:0] bit_next;

    // All-zero is a lock-up state of the shift register, so it reloads SEED instead.
    function automatic logic [7:0] prbs_next(input logic [7:0] x);
        if (x == 8'h00)
            return SEED;
        return {x[6:0], x[7] ^ x[4] ^ x[3] ^ x[2]};
    endfunction

    // The same prediction serves both searching and tracking; saturating sums carry one extra bit.
    always_comb begin
        exp_byte = prbs_next(ref_byte);
        mismatch = (data_in != exp_byte);
        bit_errs = 4'($countones(data_in ^ exp_byte));
        err_sum  = {1'b0, err_count} + {{CNT_W{1'b0}}, 1'b1};
        bit_sum  = {1'b0, bit_err_count} + (CNT_W + 1)'(bit_errs);
        err_next = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        bit_next = bit_sum[CNT_W] ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= SEARCH_FIRST;
            ref_byte      <= 8'h00;
            run           <= 4'd0;
            miss_run      <= 4'd0;
            locked        <= 1'b0;
            error         <= 1'b0;
            err_count     <= '0;
            bit_err_count <= '0;
        end else begin
            error <= 1'b0;
            if (data_valid) begin
                case (state)
                    SEARCH_FIRST: begin
                        ref_byte <= data_in;
                        run      <= 4'd0;
                        state    <= SEARCH;
                    end
                    SEARCH: begin
                        ref_byte <= data_in;
                        if (mismatch) begin
                            run <= 4'd0;
                        end else if (run + 4'd1 == LOCK_N) begin
                            run      <= 4'd0;
                            miss_run <= 4'd0;
                            state    <= LOCKED;
                            locked   <= 1'b1;
                        end else begin
                            run <= run + 4'd1;
                        end
                    end
                    LOCKED: begin
                        // The reference free-runs here; received bytes never reload it.
                        ref_byte <= exp_byte;
                        if (mismatch) begin
                            error         <= 1'b1;
                            err_count     <= err_next;
                            bit_err_count <= bit_next;
                            if (miss_run + 4'd1 == UNLOCK_N) begin
                                miss_run <= 4'd0;
                                state    <= SEARCH_FIRST;
                                locked   <= 1'b0;
                            end else begin
                                miss_run <= miss_run + 4'd1;
                            end
                        end else begin
                            miss_run <= 4'd0;
                        end
                    end
                    default: begin
                        state  <= SEARCH_FIRST;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clear) begin
                err_count     <= '0;
                bit_err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: two instances (16-bit and 4-bit counters) share one stimulus
// and are compared every cycle against a queue-based model of the lock/unlock rules.
module tb_prbs8_checker;

    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        clear = 1'b0;

    logic        locked16, error16;
    logic [15:0] err_count16, bit_err_count16;
    logic        locked4, error4;
    logic [3:0]  err_count4, bit_err_count4;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    prbs8_checker #(.SEED(8'hBC), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT), .CNT_W(16)) dut16 (
        .clk(clk), .resetn(resetn), .data_in(data_in), .data_valid(data_valid), .clear(clear),
        .locked(locked16), .error(error16), .err_count(err_count16), .bit_err_count(bit_err_count16)
    );

    prbs8_checker #(.SEED(8'hBC), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .data_in(data_in), .data_valid(data_valid), .clear(clear),
        .locked(locked4), .error(error4), .err_count(err_count4), .bit_err_count(bit_err_count4)
    );

    function automatic logic [7:0] prbs_next(input logic [7:0] x);
        if (x == 8'h00)
            return 8'hBC;
        return {x[6:0], x[7] ^ x[4] ^ x[3] ^ x[2]};
    endfunction

    // Model: lock when the last LOCK_COUNT+1 bytes since search entry form an unbroken chain,
    // unlock when the last UNLOCK_COUNT predictions all missed; counters are exact integers.
    logic [7:0] hist[$];
    bit         miss_q[$];
    bit         m_live = 1'b0;
    bit         m_locked, m_error;
    logic [7:0] m_ref;
    int         m_errs, m_bits;

    function automatic bit chain_ok();
        for (int i = 1; i < hist.size(); i++)
            if (hist[i] != prbs_next(hist[i-1]))
                return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_missed();
        foreach (miss_q[i])
            if (!miss_q[i])
                return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_live   = 1'b1;
            m_locked = 1'b0;
            m_error  = 1'b0;
            m_ref    = 8'h00;
            m_errs   = 0;
            m_bits   = 0;
            hist.delete();
            miss_q.delete();
        end else begin
            m_error = 1'b0;
            if (data_valid) begin
                if (!m_locked) begin
                    hist.push_back(data_in);
                    if (hist.size() > LOCK_COUNT + 1)
                        void'(hist.pop_front());
                    if (hist.size() == LOCK_COUNT + 1 && chain_ok()) begin
                        m_locked = 1'b1;
                        m_ref    = data_in;
                        miss_q.delete();
                    end
                end else begin
                    m_ref = prbs_next(m_ref);
                    miss_q.push_back(data_in != m_ref);
                    if (miss_q.size() > UNLOCK_COUNT)
                        void'(miss_q.pop_front());
                    if (data_in != m_ref) begin
                        m_error = 1'b1;
                        m_errs  = m_errs + 1;
                        m_bits  = m_bits + $countones(data_in ^ m_ref);
                    end
                    if (miss_q.size() == UNLOCK_COUNT && all_missed()) begin
                        m_locked = 1'b0;
                        hist.delete();
                    end
                end
            end
            if (clear) begin
                m_errs = 0;
                m_bits = 0;
            end
        end
    end

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check_output("locked16", 32'(locked16), 32'(m_locked));
            check_output("error16", 32'(error16), 32'(m_error));
            check_output("err_count16", 32'(err_count16), 32'(sat(m_errs, 16'hFFFF)));
            check_output("bit_err_count16", 32'(bit_err_count16), 32'(sat(m_bits, 16'hFFFF)));
            check_output("locked4", 32'(locked4), 32'(m_locked));
            check_output("error4", 32'(error4), 32'(m_error));
            check_output("err_count4", 32'(err_count4), 32'(sat(m_errs, 15)));
            check_output("bit_err_count4", 32'(bit_err_count4), 32'(sat(m_bits, 15)));
        end
    end

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic c, input logic r);
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        clear      = c;
        resetn     = r;
    endtask

    task automatic send(input logic [7:0] d);
        apply_stimulus(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] gen;
    logic [7:0] lock_run [5] = '{8'hBC, 8'h78, 8'hF0, 8'hE0, 8'hC1};

    initial begin
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check_output("reset_locked", 32'(locked16), 32'd0);
        check_output("reset_err_count", 32'(err_count16), 32'd0);

        // Lock sequence with idle gaps: only valid cycles count.
        send(8'hBC); idle(); send(8'h78); idle(); idle(); send(8'hF0);
        send(8'hE0); settle();
        check_output("not_locked_after_E0", 32'(locked16), 32'd0);
        idle(); send(8'hC1); settle();
        check_output("locked_after_C1", 32'(locked16), 32'd1);
        check_output("no_error_in_search", 32'(err_count16), 32'd0);

        // Single-bit error, then the free-running reference accepts 07.
        send(8'h82); settle();
        check_output("error_on_82", 32'(error16), 32'd1);
        check_output("err_count_after_82", 32'(err_count16), 32'd1);
        check_output("bit_err_after_82", 32'(bit_err_count16), 32'd1);
        send(8'h07); settle();
        check_output("no_error_on_07", 32'(error16), 32'd0);

        // Expected 0F,1E,3D,7B; zeros miss by 4,4,5,6 bits.
        send(8'h00); send(8'h00); send(8'h00); settle();
        check_output("still_locked_3_misses", 32'(locked16), 32'd1);
        send(8'h00); settle();
        check_output("unlocked_4_misses", 32'(locked16), 32'd0);
        check_output("err_count_after_garbage", 32'(err_count16), 32'd5);
        check_output("bit_err_after_garbage", 32'(bit_err_count16), 32'd20);

        // Relock and track a longer clean stretch with gaps.
        foreach (lock_run[i]) send(lock_run[i]);
        gen = 8'hC1;
        for (int i = 0; i < 24; i++) begin
            gen = prbs_next(gen);
            send(gen);
            if (i % 5 == 2) idle();
        end

        // 00 -> SEED counts as a correct step while searching.
        repeat (4) send(8'h00);
        send(8'h00); send(8'hBC); send(8'h78); send(8'hF0); send(8'hE0); settle();
        check_output("lock_via_00_BC", 32'(locked16), 32'd1);
        repeat (4) send(8'h00);
        send(8'h00); send(8'h01); send(8'hBC); send(8'h78); send(8'hF0); send(8'hE0); settle();
        check_output("00_01_breaks_run", 32'(locked16), 32'd0);
        send(8'hC1); settle();
        check_output("relock_after_break", 32'(locked16), 32'd1);

        // 20 single-bit mismatches interleaved with good bytes: the 4-bit counter saturates.
        gen = 8'hC1;
        for (int i = 0; i < 20; i++) begin
            gen = prbs_next(gen);
            send(gen ^ 8'h01);
            gen = prbs_next(gen);
            send(gen);
        end
        settle();
        check_output("err_count4_saturated", 32'(err_count4), 32'hF);
        check_output("bit_err4_saturated", 32'(bit_err_count4), 32'hF);
        repeat (3) idle();
        check_output("err_count4_held", 32'(err_count4), 32'hF);

        gen = prbs_next(gen);
        apply_stimulus(1'b1, gen ^ 8'h10, 1'b1, 1'b1); settle();
        check_output("clear_wins_count", 32'(err_count4), 32'd0);
        check_output("clear_error_pulse", 32'(error4), 32'd1);
        gen = prbs_next(gen);
        send(gen ^ 8'h03); settle();
        check_output("count_after_clear", 32'(bit_err_count16), 32'd2);

        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0); settle();
        check_output("reset_drops_lock", 32'(locked16), 32'd0);
        check_output("reset_zeroes_count", 32'(err_count16), 32'd0);
        idle(); idle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
